// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud-rate divisor.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } uart_state_t;

   function automatic int clks_per_bit(input int clock_rate, input int baud_rate);
      return clock_rate / baud_rate;
   endfunction

endpackage

// File: rtl/uart8_rx_sync2.sv
// Two-flop synchronizer for a single asynchronous bit, with selectable reset value.
module sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic i_reset,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk) begin
      if (i_reset) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/uart8_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle valid strobe, single framing_err per break.
module uart8_rx
   import uart_pkg::*;
#(
   parameter int CLOCK_RATE = 100_000_000,
   parameter int BAUD_RATE  = 115_200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] out,
   output logic       valid,
   output logic       framing_err,
   output logic       busy
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_RATE, BAUD_RATE);
   localparam int HALF         = CLKS_PER_BIT / 2;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);

   generate
      if (CLKS_PER_BIT < 4) begin : g_rate_check
         $error("uart8_rx: CLOCK_RATE/BAUD_RATE must be at least 4");
      end
   endgenerate

   logic w_rx_s;

   sync2 #(
      .RESET_VAL(1'b1)
   ) u_sync (
      .clk     (clk),
      .i_reset (reset),
      .i_d     (rx),
      .o_q     (w_rx_s)
   );

   uart_state_t      r_state;
   uart_state_t      w_state_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   logic [2:0]       r_bit_idx;
   logic [2:0]       w_bit_idx_next;
   logic [7:0]       r_shift;
   logic [7:0]       w_shift_next;
   logic [7:0]       r_out;
   logic [7:0]       w_out_next;
   logic             r_valid;
   logic             w_valid_next;
   logic             r_ferr;
   logic             w_ferr_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_out     <= 8'h00;
         r_valid   <= 1'b0;
         r_ferr    <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         r_bit_idx <= w_bit_idx_next;
         r_shift   <= w_shift_next;
         r_out     <= w_out_next;
         r_valid   <= w_valid_next;
         r_ferr    <= w_ferr_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_cnt_next     = r_cnt + 1'b1;
      w_bit_idx_next = r_bit_idx;
      w_shift_next   = r_shift;
      w_out_next     = r_out;
      w_valid_next   = 1'b0;
      w_ferr_next    = 1'b0;

      case (r_state)
         IDLE: begin
            w_cnt_next = '0;
            if (!w_rx_s) begin
               w_state_next = START;
            end
         end
         START: begin
            // A start bit that has gone high again by its midpoint was a glitch.
            if (r_cnt == HALF_END) begin
               w_cnt_next = '0;
               if (w_rx_s) begin
                  w_state_next = IDLE;
               end else begin
                  w_state_next   = DATA;
                  w_bit_idx_next = '0;
               end
            end
         end
         DATA: begin
            if (r_cnt == BIT_END) begin
               w_cnt_next              = '0;
               w_shift_next[r_bit_idx] = w_rx_s;
               if (r_bit_idx == 3'd7) begin
                  w_state_next = STOP;
               end else begin
                  w_bit_idx_next = r_bit_idx + 3'd1;
               end
            end
         end
         STOP: begin
            if (r_cnt == BIT_END) begin
               w_cnt_next = '0;
               if (w_rx_s) begin
                  w_out_next   = r_shift;
                  w_valid_next = 1'b1;
                  w_state_next = IDLE;
               end else begin
                  w_ferr_next  = 1'b1;
                  w_state_next = BREAK;
               end
            end
         end
         BREAK: begin
            // Parked here so a held-low line reports only one framing error.
            w_cnt_next = '0;
            if (w_rx_s) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_cnt_next   = '0;
            w_state_next = IDLE;
         end
      endcase
   end

   assign out         = r_out;
   assign valid       = r_valid;
   assign framing_err = r_ferr;
   assign busy        = (r_state != IDLE);

endmodule
